fir_decim_requant: RTL and testbench
====================================

Name: fir_decim_requant

Overview:
- Sits directly downstream of the 41-tap FIR low-pass filter.
- Takes the filter's 41-bit signed full-precision sum, decimates by DECIM, rescales by an arithmetic right shift and saturates to OUT_W bits.
- Buffers results in a small FIFO behind a valid/ready handshake, so the slow consumer (packetiser/DMA) can apply backpressure without stalling the free-running FIR.

Parameters:
- IN_W, 41: input sample width, signed.
- OUT_W, 16: output sample width, signed.
- DECIM, 4: decimation factor, ≥1; keep 1 of every DECIM valid inputs.
- SHIFT, 15: arithmetic right shift applied before saturation, 1..IN_W-2. FIR DC gain ≈ 17583 < 2^15.
- FIFO_DEPTH, 4: output FIFO entries; power of two, ≥2.

Ports:
- clk, input, 1: system clock; all state on rising edge.
- rst_n, input, 1: asynchronous active-low reset; deassertion synchronised externally.
- in_valid, input, 1: in_data valid this cycle (tie high when FIR runs every clock).
- in_data, input, IN_W: signed FIR output sample.
- out_valid, output, 1: FIFO non-empty.
- out_ready, input, 1: consumer accepts out_data this cycle.
- out_data, output, OUT_W: signed requantised sample, FIFO head.
- overflow, output, 1: sticky; a decimated sample was dropped because the FIFO was full.
- sat_cnt, output, 8: saturating count of clipped samples.

Behaviour:
- Reset, async on rst_n low:
  - phase=0, stage-1 valid=0, FIFO empty (rd/wr pointers and count = 0).
  - out_valid=0, out_data=0, overflow=0, sat_cnt=0.
  - Reset mid-operation discards all buffered and in-flight samples.
- Decimation:
  - phase counter 0..DECIM-1 advances only on in_valid and wraps DECIM-1→0.
  - A sample is kept when in_valid=1 and phase==0. The first valid sample after reset is kept.
  - in_valid=0 holds phase.
- Stage 1 (registered):
  - Kept sample is sign-extended; optional rounding is applied (see below), then arithmetic shift right by SHIFT.
  - Result > 2^(OUT_W-1)-1 clips to 0x7FFF; result < -2^(OUT_W-1) clips to 0x8000 (OUT_W=16).
  - Each clip increments sat_cnt, which sticks at 255.
  - The stage-1 register carries the result plus a valid bit.
- Stage 2, FIFO push:
  - Stage-1 valid pushes at the next edge.
  - Latency: sample accepted at edge N → out_valid=1 with that data in the cycle following edge N+1 (2 clocks), when the FIFO is otherwise empty.
- Pop: out_valid && out_ready at an edge removes the head.
  - out_data must be stable while out_valid=1 and out_ready=0.
  - out_data=0 whenever out_valid=0.
- Full: push while count==FIFO_DEPTH with no simultaneous pop → new sample dropped, FIFO contents unchanged, overflow←1. overflow clears only on reset.
- Simultaneous push+pop:
  - When full: legal; count unchanged, no drop.
  - When empty: only a push occurs, because out_valid=0 blocks the pop.
- Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- No combinational path from out_ready to any input, or from in_valid to any output.

Optional Feature:
- Macro FIR_DECIM_ROUND_EN.
- Defined: add 2^(SHIFT-1) before the shift, giving round-half-up (toward +inf). The addition is performed at IN_W+1 bits so it cannot wrap; saturation follows.
- Undefined: plain arithmetic shift, i.e. truncation toward -inf.
- Latency identical in both builds.

Test Plan:
- Decimation/latency: DECIM=4, SHIFT=15, in_valid=1, out_ready=1, in_data=100·2^15 constant → out_data=100 every 4th cycle, first out_valid 2 clocks after first input edge; 8 inputs → exactly 2 outputs.
- Rounding: in_data=49152 → 1 (ROUND off) / 2 (ROUND on); in_data=-49152 → -2 (off) / -1 (on); in_data=-3276800 → -100 in both builds.
- Saturation: in_data=2^40-1 → 32767; in_data=-2^40 → -32768; sat_cnt=2; 300 clipping samples → sat_cnt=255.
- Backpressure/overflow: out_ready=0, 20 inputs (5 kept) → out_valid=1, first 4 values retained in order, 5th dropped, overflow=1. Then out_ready=1 → 4 pops and out_valid=0; overflow stays 1.
- Full push+pop: FIFO full, out_ready=1 while a kept sample arrives → no drop, overflow stays 0, output order preserved.
- Async reset mid-stream: rst_n low for half a cycle with 3 entries buffered → out_valid, out_data, overflow, sat_cnt all 0 immediately. After release, the next valid input is kept at phase 0.

Source files
------------

// File: rtl/fir_decim_requant.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fir_decim_requant: decimate FIR sum, shift, saturate, buffer in FIFO.     |
// | Macro FIR_DECIM_ROUND_EN enables round-half-up before the shift. Rev 1.0  |
// +--------------------------------------------------------------------------+
module fir_decim_requant #(
  parameter int IN_W       = 41,
  parameter int OUT_W      = 16,
  parameter int DECIM      = 4,
  parameter int SHIFT      = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             overflow,
  output logic [7:0]       sat_cnt
);

  localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PH_W-1:0]     C_PH_LAST = PH_W'(DECIM - 1);
  localparam logic [CNT_W-1:0]    C_DEPTH   = CNT_W'(FIFO_DEPTH);
  localparam logic signed [IN_W:0] C_MAX = {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [IN_W:0] C_MIN = {{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};
  localparam logic signed [IN_W:0] C_HALF = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);

  // ---------------- decimation and requantisation ----------------
  logic [PH_W-1:0]  phase_q, phase_d;
  logic             keep;
  logic signed [IN_W:0] ext, biased, shifted;
  logic             clip;
  logic [OUT_W-1:0] req;

  logic             s1_valid_q;
  logic [OUT_W-1:0] s1_data_q;
  logic [7:0]       sat_cnt_q, sat_cnt_d;

  always_comb begin
    keep    = in_valid && (phase_q == '0);
    phase_d = phase_q;
    if (in_valid) begin
      phase_d = (phase_q == C_PH_LAST) ? '0 : phase_q + PH_W'(1);
    end

    // One extra bit of headroom so the rounding offset can never wrap
    ext = {in_data[IN_W-1], in_data};
`ifdef FIR_DECIM_ROUND_EN
    biased = ext + C_HALF;
`else
    biased = ext;
`endif
    shifted = biased >>> SHIFT;

    clip = 1'b1;
    if (shifted > C_MAX) begin
      req = {1'b0, {(OUT_W - 1){1'b1}}};
    end else if (shifted < C_MIN) begin
      req = {1'b1, {(OUT_W - 1){1'b0}}};
    end else begin
      req  = shifted[OUT_W-1:0];
      clip = 1'b0;
    end

    sat_cnt_d = sat_cnt_q;
    if (keep && clip && (sat_cnt_q != 8'hFF)) begin
      sat_cnt_d = sat_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      sat_cnt_q  <= '0;
    end else begin
      phase_q    <= phase_d;
      s1_valid_q <= keep;
      if (keep) begin
        s1_data_q <= req;
      end
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  // ---------------- output FIFO ----------------
  logic [OUT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q;
  logic             pop, full, wr_en, drop;

  always_comb begin
    pop   = (count_q != '0) && out_ready;
    full  = (count_q == C_DEPTH);
    // A full FIFO still accepts the push when the head leaves on the same edge
    wr_en = s1_valid_q && (!full || pop);
    drop  = s1_valid_q && full && !pop;

    count_d = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!wr_en && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= s1_data_q;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign overflow  = overflow_q;
  assign sat_cnt   = sat_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_decim_requant.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fir_decim_requant: scoreboard bench for fir_decim_requant.             |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_fir_decim_requant;

`ifdef FIR_DECIM_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [40:0] in_data   = '0;
  logic        out_valid;
  logic        overflow;
  logic [15:0] out_data;
  logic [7:0]  sat_cnt;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  int tb_phase = 0;
  bit drop_next = 1'b0;
  logic signed [15:0] exp_q[$];

  fir_decim_requant dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .overflow (overflow),
    .sat_cnt  (sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // One valid input per clock; the expected result is queued only for kept samples
  task automatic drive(input logic signed [63:0] v, input logic signed [15:0] e);
    in_valid = 1'b1;
    in_data  = v[40:0];
    if (tb_phase == 0) begin
      if (drop_next) drop_next = 1'b0;
      else exp_q.push_back(e);
    end
    tb_phase = (tb_phase + 1) % 4;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic keep_one(input logic signed [63:0] v, input logic signed [15:0] e);
    drive(v, e);
    repeat (3) drive(64'sd0, 16'sd0);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: compare every handshake against the scoreboard queue
  logic [15:0] held;
  bit holding = 1'b0;
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (holding) check("hold_stable", out_data, held);
      if (out_ready) begin
        pops++;
        holding = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%0d required=none", $signed(out_data));
        end else begin
          check("out_data", $signed(out_data), exp_q.pop_front());
        end
      end else begin
        holding = 1'b1;
        held    = out_data;
      end
    end else begin
      holding = 1'b0;
      if (rst_n) check("idle_data_zero", out_data, 0);
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_sat_cnt", sat_cnt, 0);
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Decimation and latency
    out_ready = 1'b1;
    drive(64'sd3276800, 16'sd100);
    check("lat_one_clk", out_valid, 0);
    drive(64'sd3276800, 16'sd0);
    check("lat_two_clk", out_valid, 1);
    check("lat_data", out_data, 100);
    repeat (6) drive(64'sd3276800, 16'sd100);
    wait_drain("decim_drain");
    check("decim_pops", pops, 2);

    // Rounding
    keep_one(64'sd49152, RND ? 16'sd2 : 16'sd1);
    keep_one(-64'sd49152, RND ? -16'sd1 : -16'sd2);
    keep_one(-64'sd3276800, -16'sd100);
    wait_drain("round_drain");

    // Saturation
    keep_one(64'sh0000_00FF_FFFF_FFFF, 16'sd32767);
    keep_one(-64'sh0000_0100_0000_0000, -16'sd32768);
    check("sat_cnt_2", sat_cnt, 2);
    repeat (298) keep_one(64'sh0000_00FF_FFFF_FFFF, 16'sd32767);
    check("sat_cnt_255", sat_cnt, 255);
    wait_drain("sat_drain");

    // Full FIFO with push and pop on the same edge
    out_ready = 1'b0;
    for (int k = 11; k <= 14; k++) keep_one(64'(k) <<< 15, 16'(k));
    drive(64'sd15 <<< 15, 16'sd15);
    out_ready = 1'b1;
    drive(64'sd0, 16'sd0);
    out_ready = 1'b0;
    check("full_pushpop_no_ovf", overflow, 0);
    drive(64'sd0, 16'sd0);
    drive(64'sd0, 16'sd0);
    out_ready = 1'b1;
    wait_drain("full_pushpop_drain");
    check("full_pushpop_ovf_after", overflow, 0);

    // Backpressure and overflow
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) keep_one(64'(k) <<< 15, 16'(k));
    drop_next = 1'b1;
    keep_one(64'sd5 <<< 15, 16'sd5);
    check("bp_out_valid", out_valid, 1);
    check("bp_overflow", overflow, 1);
    check("bp_head", out_data, 1);
    out_ready = 1'b1;
    wait_drain("bp_drain");
    check("bp_empty", out_valid, 0);
    check("bp_overflow_sticky", overflow, 1);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    for (int k = 7; k <= 9; k++) keep_one(64'(k) <<< 15, 16'(k));
    drive(64'sd0, 16'sd0);
    drive(64'sd0, 16'sd0);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    check("arst_overflow", overflow, 0);
    check("arst_sat_cnt", sat_cnt, 0);
    exp_q.delete();
    tb_phase = 0;
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    keep_one(64'sd3276800, 16'sd100);
    wait_drain("post_reset_drain");
    check("post_reset_sat_cnt", sat_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
